// File: rtl/dmem_cache_ctrl_if.sv
// Backing data-memory bus between the cache controller (master) and the memory (slave).
interface dmem_cache_ctrl_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_rd,
    output mem_wr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_rd,
    input  mem_wr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped write-back data cache controller with halt-time flush of dirty lines.
// Define DMEM_CACHE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module dmem_cache_ctrl #(
  parameter int unsigned INDEX_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       Addr,
  input  logic [15:0]       DataIn,
  input  logic              Rd,
  input  logic              Wr,
  input  logic              halt,
  output logic [15:0]       DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              FlushDone,
  output logic              err,
`ifdef DMEM_CACHE_CTRL_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  dmem_cache_ctrl_if.master mem
);

  localparam int unsigned Lines  = 1 << INDEX_W;
  localparam int unsigned TagW   = 15 - INDEX_W;
  localparam int unsigned FlushW = INDEX_W + 1;
  localparam int unsigned CntW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWback,
    StFill,
    StFlush,
    StHalted
  } state_e;

  state_e state_q, state_d;

  // Latched request; addr_q drops the always-zero byte bit.
  logic [15:1]        addr_q;
  logic [15:0]        wdata_q;
  logic               rd_q;
  logic               wr_q;
  logic               fill_q;
  logic               err_q;
  logic [FlushW-1:0]  flush_q;
  logic [CntW-1:0]    cnt_q;

  logic [Lines-1:0]   valid_q;
  logic [Lines-1:0]   dirty_q;
  logic [TagW-1:0]    tag_q  [Lines];
  logic [15:0]        data_q [Lines];

  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] flush_idx;
  logic [INDEX_W-1:0] wb_idx;
  logic [TagW-1:0]    req_tag;
  logic               hit;
  logic               victim_dirty;
  logic               flush_dirty;
  logic               tmo;

  logic               latch_req;
  logic               set_err;
  logic               do_store;
  logic               do_fill;
  logic               clr_dirty;
  logic               clr_fill;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               flush_start;
  logic               flush_adv;

  assign req_idx      = addr_q[INDEX_W:1];
  assign req_tag      = addr_q[15:INDEX_W+1];
  assign flush_idx    = flush_q[INDEX_W-1:0];
  // Write-back source line: the scan pointer while flushing, else the request's victim.
  assign wb_idx       = (state_q == StFlush) ? flush_idx : req_idx;
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign flush_dirty  = valid_q[flush_idx] && dirty_q[flush_idx];
  assign tmo          = (cnt_q == CntW'(MEM_TIMEOUT - 1));
  assign FlushDone    = (state_q == StHalted);
  assign err          = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    Done          = 1'b0;
    CacheHit      = 1'b0;
    Stall         = 1'b0;
    DataOut       = '0;
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    latch_req     = 1'b0;
    set_err       = 1'b0;
    do_store      = 1'b0;
    do_fill       = 1'b0;
    clr_dirty     = 1'b0;
    clr_fill      = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    flush_start   = 1'b0;
    flush_adv     = 1'b0;

    case (state_q)
      StIdle: begin
        // A pending request always wins over halt; halt is re-sampled back in idle.
        if (Rd || Wr) begin
          if ((Rd && Wr) || Addr[0]) begin
            set_err = 1'b1;
          end else begin
            latch_req = 1'b1;
            Stall     = 1'b1;
            state_d   = StCompare;
          end
        end else if (halt) begin
          flush_start = 1'b1;
          cnt_clr     = 1'b1;
          Stall       = 1'b1;
          state_d     = StFlush;
        end
      end

      StCompare: begin
        clr_fill = 1'b1;
        if (hit) begin
          Done     = 1'b1;
          CacheHit = !fill_q;
          if (rd_q) begin
            DataOut = data_q[req_idx];
          end
          do_store = wr_q;
          state_d  = StIdle;
        end else begin
          Stall   = 1'b1;
          cnt_clr = 1'b1;
          state_d = victim_dirty ? StWback : StFill;
        end
      end

      StWback: begin
        Stall         = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = {tag_q[wb_idx], wb_idx, 1'b0};
        mem.mem_wdata = data_q[wb_idx];
        if (mem.mem_ready) begin
          clr_dirty = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = StFill;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = StHalted;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      StFill: begin
        Stall        = 1'b1;
        mem.mem_rd   = 1'b1;
        mem.mem_addr = {addr_q, 1'b0};
        if (mem.mem_ready) begin
          do_fill = 1'b1;
          state_d = StCompare;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = StHalted;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      StFlush: begin
        Stall = 1'b1;
        if (flush_q[INDEX_W]) begin
          state_d = StHalted;
        end else if (flush_dirty) begin
          mem.mem_wr    = 1'b1;
          mem.mem_addr  = {tag_q[wb_idx], wb_idx, 1'b0};
          mem.mem_wdata = data_q[wb_idx];
          if (mem.mem_ready) begin
            clr_dirty = 1'b1;
            flush_adv = 1'b1;
            cnt_clr   = 1'b1;
          end else if (tmo) begin
            set_err = 1'b1;
            state_d = StHalted;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          flush_adv = 1'b1;
          cnt_clr   = 1'b1;
        end
      end

      StHalted: begin
        state_d = StHalted;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
      flush_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (latch_req) begin
        addr_q  <= Addr[15:1];
        wdata_q <= DataIn;
        rd_q    <= Rd;
        wr_q    <= Wr;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (flush_start) begin
        flush_q <= '0;
      end else if (flush_adv) begin
        flush_q <= flush_q + FlushW'(1);
      end
      if (do_fill) begin
        fill_q <= 1'b1;
      end else if (clr_fill) begin
        fill_q <= 1'b0;
      end
      if (do_fill) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end else if (do_store) begin
        dirty_q[req_idx] <= 1'b1;
      end else if (clr_dirty) begin
        dirty_q[wb_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem.mem_rdata;
    end else if (do_store) begin
      data_q[req_idx] <= wdata_q;
    end
  end

`ifdef DMEM_CACHE_CTRL_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = Done && CacheHit;
  assign miss_evt = (state_q != StFill) && (state_d == StFill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss_evt && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Randomised self-checking bench for dmem_cache_ctrl: word-level memory image plus
// a tag/valid/dirty line model decide hits, expected bus traffic and the final image.
module tb_dmem_cache_ctrl;
  localparam int unsigned IndexW  = 4;
  localparam int unsigned Lines   = 1 << IndexW;
  localparam int unsigned TagW    = 15 - IndexW;
  localparam int unsigned Timeout = 64;
  localparam int unsigned Words   = 256;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        halt;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        FlushDone;
  logic        err;
`ifdef DMEM_CACHE_CTRL_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dmem_cache_ctrl_if mem ();

  dmem_cache_ctrl #(
    .INDEX_W    (IndexW),
    .MEM_TIMEOUT(Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .Rd        (Rd),
    .Wr        (Wr),
    .halt      (halt),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .FlushDone (FlushDone),
    .err       (err),
`ifdef DMEM_CACHE_CTRL_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .mem       (mem)
  );

  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  txn_t        log_q[$];
  logic [15:0] img     [Words];
  logic [15:0] ref_mem [Words];
  bit          m_valid [Lines];
  bit          m_dirty [Lines];
  logic [TagW-1:0] m_tag [Lines];
  bit          stuck;
  bit          both_seen;
  int          lat_cnt;
  int          lat_tgt;
  int          lat_fixed;
  int          rd_cycles;
  int          rd_addr_bad;
  logic [15:0] watch_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  // One clock step: wait for the falling edge, then act as the backing memory.
  task automatic tick();
    txn_t t;
    @(negedge clk);
    mem.mem_ready = 1'b0;
    if (mem.mem_rd && mem.mem_wr) both_seen = 1'b1;
    if (mem.mem_rd) begin
      rd_cycles++;
      if (mem.mem_addr !== watch_addr) rd_addr_bad++;
    end
    if ((mem.mem_rd || mem.mem_wr) && !stuck) begin
      if (lat_cnt == 0) lat_tgt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      if (lat_cnt >= lat_tgt) begin
        mem.mem_ready = 1'b1;
        t.wr   = mem.mem_wr;
        t.addr = mem.mem_addr;
        if (mem.mem_wr) begin
          t.data = mem.mem_wdata;
          img[widx(mem.mem_addr)] = mem.mem_wdata;
        end else begin
          mem.mem_rdata = img[widx(mem.mem_addr)];
          t.data = mem.mem_rdata;
        end
        log_q.push_back(t);
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < Lines; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int w = 0; w < Words; w++) ref_mem[w] = img[w];
    log_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; halt = 1'b0; stuck = 1'b0; lat_fixed = -1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    int unsigned       w;
    logic [IndexW-1:0] idx;
    logic [TagW-1:0]   tag;
    bit                exp_hit;
    bit                got;
    int                cyc;
    int                base;
    txn_t              t;
    txn_t              exp_q[$];
    w   = widx(a);
    idx = a[IndexW:1];
    tag = a[15:IndexW+1];
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!exp_hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        t.wr = 1'b1;
        t.addr = {m_tag[idx], idx, 1'b0};
        t.data = ref_mem[widx(t.addr)];
        exp_q.push_back(t);
      end
      t.wr = 1'b0; t.addr = a; t.data = ref_mem[w];
      exp_q.push_back(t);
    end
    base = log_q.size();
    both_seen = 1'b0;
    watch_addr = a;
    Addr = a; DataIn = d; Rd = rd; Wr = wr;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 400) begin
      tick();
      cyc++;
      if (Done) got = 1'b1;
    end
    Rd = 1'b0; Wr = 1'b0;
    check_eq("done_seen", got, 1);
    if (got) begin
      check_eq("cache_hit", CacheHit, exp_hit);
      check_eq("stall_on_done", Stall, 0);
      if (rd) check_eq("load_data", DataOut, ref_mem[w]);
      if (exp_hit) check_eq("hit_latency", cyc, 1);
      check_eq("txn_count", log_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (base + i < log_q.size()) begin
          check_eq("txn_kind", log_q[base+i].wr, exp_q[i].wr);
          check_eq("txn_addr", log_q[base+i].addr, exp_q[i].addr);
          check_eq("txn_data", log_q[base+i].data, exp_q[i].data);
        end
      end
      check_eq("rd_wr_excl", both_seen, 0);
    end
    tick();
    check_eq("done_pulse", Done, 0);
    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      ref_mem[w]   = d;
    end
  endtask

  task automatic do_flush(output int n_wr);
    txn_t t;
    txn_t exp_q[$];
    int   base;
    int   cyc;
    int   bad;
    for (int i = 0; i < Lines; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        t.wr = 1'b1;
        t.addr = {m_tag[i], IndexW'(i), 1'b0};
        t.data = ref_mem[widx(t.addr)];
        exp_q.push_back(t);
      end
    end
    base = log_q.size();
    both_seen = 1'b0;
    halt = 1'b1;
    cyc = 0;
    while (!FlushDone && cyc < 2000) begin
      tick();
      cyc++;
    end
    halt = 1'b0;
    check_eq("flush_done", FlushDone, 1);
    check_eq("halted_stall", Stall, 0);
    check_eq("flush_err", err, 0);
    n_wr = log_q.size() - base;
    check_eq("flush_count", n_wr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size()) begin
        check_eq("flush_kind", log_q[base+i].wr, 1);
        check_eq("flush_addr", log_q[base+i].addr, exp_q[i].addr);
        check_eq("flush_data", log_q[base+i].data, exp_q[i].data);
      end
    end
    bad = 0;
    for (int w = 0; w < Words; w++) if (img[w] !== ref_mem[w]) bad++;
    check_eq("final_image", bad, 0);
    for (int i = 0; i < Lines; i++) m_dirty[i] = 1'b0;
  endtask

  initial begin
    int n_wr;
    int cyc;
    logic [15:0] a;
    n_vec = 0; n_err = 0;
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; halt = 1'b0; Addr = '0; DataIn = '0;
    stuck = 1'b0; lat_cnt = 0; lat_tgt = 0; lat_fixed = -1; both_seen = 1'b0;
    rd_cycles = 0; rd_addr_bad = 0; watch_addr = '0;
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    for (int w = 0; w < Words; w++) img[w] = 16'($urandom);

    tick();
    check_eq("reset_ctrl", {Done, Stall, CacheHit, FlushDone, err, mem.mem_rd, mem.mem_wr}, 0);
    check_eq("reset_dataout", DataOut, 0);
    apply_reset();

    // Cold load with a three-cycle memory, then a hit on the same word.
    img[8] = 16'hBEEF;
    model_clear();
    lat_fixed = 3;
    rd_cycles = 0; rd_addr_bad = 0;
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);
    check_eq("cold_rd_cycles", rd_cycles, 4);
    check_eq("cold_rd_addr", rd_addr_bad, 0);
    check_eq("cold_data", DataOut, 16'h0000);
    rd_cycles = 0;
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);
    check_eq("warm_no_rd", rd_cycles, 0);

    // Store hit followed by a conflicting load on index 8.
    do_req(1'b0, 1'b1, 16'h0010, 16'h1234);
    do_req(1'b1, 1'b0, 16'h0030, 16'h0000);
    lat_fixed = -1;

    for (int n = 0; n < 250; n++) begin
      a = {7'd0, 8'($urandom_range(0, 63)), 1'b0};
      if ($urandom_range(0, 1) == 1) do_req(1'b0, 1'b1, a, 16'($urandom));
      else do_req(1'b1, 1'b0, a, 16'h0000);
    end
    do_flush(n_wr);

    // Only lines 2 and 15 dirty.
    apply_reset();
    do_req(1'b0, 1'b1, 16'h0004, 16'hA5A5);
    do_req(1'b0, 1'b1, 16'h001E, 16'h5A5A);
    do_req(1'b1, 1'b0, 16'h000A, 16'h0000);
    do_flush(n_wr);
    check_eq("flush_two", n_wr, 2);

    // Illegal requests.
    apply_reset();
    Addr = 16'h0020; Rd = 1'b1; Wr = 1'b1;
    tick();
    check_eq("both_err", err, 1);
    check_eq("both_stall", Stall, 0);
    tick();
    check_eq("both_no_mem", {mem.mem_rd, mem.mem_wr}, 0);
    Rd = 1'b0; Wr = 1'b0;
    tick();
    check_eq("both_no_txn", log_q.size(), 0);
    apply_reset();
    check_eq("err_cleared", err, 0);
    Addr = 16'h0011; Rd = 1'b1;
    tick();
    check_eq("odd_err", err, 1);
    check_eq("odd_stall", Stall, 0);
    tick();
    check_eq("odd_no_mem", {mem.mem_rd, mem.mem_wr}, 0);
    Rd = 1'b0;
    tick();
    check_eq("odd_no_txn", log_q.size(), 0);

    // Fill that never completes.
    apply_reset();
    stuck = 1'b1;
    rd_cycles = 0;
    watch_addr = 16'h0040;
    Addr = 16'h0040; Rd = 1'b1;
    tick();
    Rd = 1'b0;
    cyc = 0;
    while (!FlushDone && cyc < 300) begin
      tick();
      cyc++;
    end
    check_eq("tmo_rd_cycles", rd_cycles, Timeout);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_rd_drop", mem.mem_rd, 0);
    check_eq("tmo_halted", FlushDone, 1);

    // Reset while a fill is outstanding.
    apply_reset();
    stuck = 1'b1;
    Addr = 16'h0050; Rd = 1'b1;
    tick();
    Rd = 1'b0;
    tick();
    tick();
    tick();
    check_eq("fill_pending", mem.mem_rd, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_drop", mem.mem_rd, 0);
    tick();
    tick();
    rst = 1'b0;
    stuck = 1'b0;
    model_clear();
    tick();
    do_req(1'b1, 1'b0, 16'h0050, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0050, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_cache_ctrl.md
Name: dmem_cache_ctrl

Overview:
- Direct-mapped, write-back data cache controller. Sits downstream of the memory stage (EXMEM outputs) and upstream of a multi-cycle backing data memory.
- Services one load or store at a time from a table of 2^INDEX_W one-word lines.
- Drives Stall so the pipeline can freeze the PC and all pipeline registers while a miss is serviced.
- On halt, writes every dirty line back to memory so the final memory image is exact.

Parameters:
- INDEX_W, 4: line index width; 16 lines. Index = Addr[INDEX_W:1]; tag = Addr[15:INDEX_W+1].
- MEM_TIMEOUT, 64: maximum cycles to wait for mem_ready before raising err.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- Addr  in  16  byte address from ALURes of the EXMEM stage
- DataIn  in  16  store data
- Rd  in  1  load request (MemToReg of the EXMEM stage)
- Wr  in  1  store request (MemWrite of the EXMEM stage)
- halt  in  1  halt reached the memory stage; starts a flush
- DataOut  out  16  load data; valid when Done=1
- Done  out  1  one-cycle pulse: request completed
- Stall  out  1  pipeline must hold; request inputs must stay stable
- CacheHit  out  1  qualifies Done; 1 if serviced without a fill
- FlushDone  out  1  level; all dirty lines have been written back
- err  out  1  sticky error
- mem_addr  out  16  backing memory word address, byte-aligned
- mem_wdata  out  16  backing memory write data
- mem_rd  out  1  backing read request; held until mem_ready
- mem_wr  out  1  backing write request; held until mem_ready
- mem_rdata  in  16  backing read data; valid with mem_ready
- mem_ready  in  1  backing memory completes the current access this cycle

Behaviour:
- Reset (asynchronous):
  - State=IDLE; all valid and dirty bits clear.
  - All outputs 0, including DataOut. Tag and data arrays need no reset.
- States: IDLE, COMPARE, WBACK, FILL, FLUSH, HALTED.
- IDLE:
  - Rd^Wr: latch Addr/DataIn/Rd/Wr, Stall=1, go to COMPARE.
  - Rd&Wr, or (Rd|Wr) with Addr[0]=1: err<=1, no memory access, stay in IDLE.
  - halt with no request: go to FLUSH with the line counter at 0.
  - Request and halt in the same cycle: the request is serviced first; halt is sampled again on return to IDLE.
- COMPARE, hit (valid && tag match):
  - Done=1, CacheHit=1 unless this is the post-fill compare, Stall=0.
  - Load: DataOut = line data.
  - Store: line data <= DataIn, dirty <= 1.
  - Go to IDLE.
  - Hit latency: request cycle + 1; Done arrives in the second cycle.
- COMPARE, miss: Stall=1.
  - Victim valid && dirty: go to WBACK.
  - Otherwise: go to FILL.
- WBACK:
  - mem_wr=1, mem_addr = {victim tag, index, 1'b0}, mem_wdata = victim data.
  - On mem_ready: clear dirty, go to FILL.
- FILL:
  - mem_rd=1, mem_addr = {Addr[15:1], 1'b0}.
  - On mem_ready: install data, tag, valid=1, dirty=0; set the fill flag; go to COMPARE. The fill flag forces CacheHit=0 on the following Done.
- FLUSH:
  - Scans lines 0..2^INDEX_W-1, one per cycle when clean or invalid.
  - A dirty line issues mem_wr and waits for mem_ready.
  - After the last line: go to HALTED.
- HALTED: FlushDone=1, Stall=0; stays until reset.
- Memory timeout:
  - Cycle counter cleared on entry to WBACK, FILL or each FLUSH write.
  - Reaching MEM_TIMEOUT: err<=1, drop mem_rd/mem_wr, go to HALTED.
- mem_rd and mem_wr are never high together. mem_ready while neither is asserted is ignored.
- Reset mid-miss aborts the transaction: outstanding mem_* requests drop immediately and all lines become invalid.
- Index wrap in FLUSH: the counter is INDEX_W+1 bits wide; completion is MSB set.

Optional Feature:
- Macro: DMEM_CACHE_CTRL_STATS_EN.
- When defined, adds outputs hit_count[15:0] and miss_count[15:0]:
  - hit_count increments on each Done with CacheHit=1; miss_count on each entry to FILL.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold load: Rd=1, Addr=16'h0010, memory returns 16'hBEEF after 3 cycles. Expect:
  - mem_rd high with mem_addr=16'h0010 until mem_ready.
  - Done pulse with DataOut=16'hBEEF, CacheHit=0.
  - Repeating the load gives Done in the 2nd cycle with CacheHit=1, no mem_rd.
- Store hit then conflicting load:
  - Wr to 16'h0010 with 16'h1234, then Rd to 16'h0030 (same index 8, different tag).
  - Expect WBACK mem_wr with mem_addr=16'h0010, mem_wdata=16'h1234, followed by FILL of 16'h0030.
- Error cases: Rd=Wr=1, and separately Rd with Addr=16'h0011. Expect err=1, no mem_rd/mem_wr, Stall=0.
- Halt flush:
  - Dirty lines at indices 2 and 15, then halt.
  - Expect exactly two mem_wr transactions in index order, then FlushDone=1.
- Timeout: FILL with mem_ready held low. Expect err=1 and mem_rd=0 after 64 cycles; state is HALTED.
- Reset mid-miss:
  - Assert rst during FILL. Expect mem_rd=0 asynchronously.
  - The same load afterwards misses again (CacheHit=0).
